// File: rtl/panel_input_ctrl.sv
// panel_input_ctrl: two debounced active-low pushbuttons that toggle scan
// run/direction, plus a switch-selected step tick generator.
// Optional feature macro: PANEL_AUTO_REPEAT_EN (key auto-repeat while held).
module panel_input_ctrl #(
  parameter int unsigned DEBOUNCE_COUNT = 500000,
  parameter int unsigned TICK_BASE      = 2500000,
  parameter int unsigned REPEAT_DELAY   = 25000000,
  parameter int unsigned REPEAT_PERIOD  = 5000000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [1:0] KEY,
  input  logic [3:0] SW,
  output logic [1:0] key_level,
  output logic [1:0] key_pressed,
  output logic       run,
  output logic       dir_up,
  output logic       step_tick
);

  localparam int unsigned DW = $clog2(DEBOUNCE_COUNT + 1);
  localparam int unsigned TW = $clog2(16 * TICK_BASE);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_COUNT - 1);

`ifdef PANEL_AUTO_REPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RW = $clog2(RPT_MAX + 1);
  localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);
`endif

  // Zero-length timing parameters would make the counters meaningless.
  if (DEBOUNCE_COUNT == 0 || TICK_BASE == 0 || REPEAT_DELAY == 0 || REPEAT_PERIOD == 0) begin : g_bad_param
    $error("panel_input_ctrl: timing parameters must be nonzero");
  end

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} key_state_e;

  logic [1:0]    sync1_q, sync2_q, key_down;
  key_state_e    state_q [2];
  key_state_e    state_d [2];
  logic [DW-1:0] db_cnt_q [2];
  logic [DW-1:0] db_cnt_d [2];
  logic [1:0]    level_d, press_d, accept_d;
`ifdef PANEL_AUTO_REPEAT_EN
  logic [RW-1:0] rpt_cnt_q [2];
  logic [RW-1:0] rpt_cnt_d [2];
  logic [1:0]    rpt_armed_q, rpt_armed_d;
`endif
  logic [3:0]    sw_lat_q;
  logic [TW-1:0] tick_cnt_q, tick_last;

  // Two-flop synchronizer; released (1) out of reset.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
    end else begin
      sync1_q <= KEY;
      sync2_q <= sync1_q;
    end
  end

  assign key_down = ~sync2_q;

  // Per-key debounce FSM next-state and event decode.
  always_comb begin
    level_d  = key_level;
    press_d  = 2'b00;
    accept_d = 2'b00;
`ifdef PANEL_AUTO_REPEAT_EN
    rpt_armed_d = rpt_armed_q;
`endif
    for (int i = 0; i < 2; i++) begin
      state_d[i]  = state_q[i];
      db_cnt_d[i] = db_cnt_q[i];
`ifdef PANEL_AUTO_REPEAT_EN
      rpt_cnt_d[i] = rpt_cnt_q[i];
`endif
      unique case (state_q[i])
        IDLE: begin
          if (key_down[i]) begin
            state_d[i]  = PRESS_WAIT;
            db_cnt_d[i] = '0;
          end
        end
        PRESS_WAIT: begin
          if (!key_down[i]) begin
            state_d[i]  = IDLE;
            db_cnt_d[i] = '0;
          end else if (db_cnt_q[i] == DB_LAST) begin
            state_d[i]  = HELD;
            db_cnt_d[i] = '0;
            level_d[i]  = 1'b1;
            accept_d[i] = 1'b1;
            press_d[i]  = 1'b1;
`ifdef PANEL_AUTO_REPEAT_EN
            rpt_cnt_d[i]   = '0;
            rpt_armed_d[i] = 1'b0;
`endif
          end else begin
            db_cnt_d[i] = db_cnt_q[i] + DW'(1);
          end
        end
        HELD: begin
          if (!key_down[i]) begin
            state_d[i]  = RELEASE_WAIT;
            db_cnt_d[i] = '0;
          end else begin
`ifdef PANEL_AUTO_REPEAT_EN
            // First repeat after the delay, then one per period.
            if (rpt_cnt_q[i] == (rpt_armed_q[i] ? RP_LAST : RD_LAST)) begin
              rpt_cnt_d[i]   = '0;
              rpt_armed_d[i] = 1'b1;
              press_d[i]     = 1'b1;
            end else begin
              rpt_cnt_d[i] = rpt_cnt_q[i] + RW'(1);
            end
`endif
          end
        end
        RELEASE_WAIT: begin
          if (key_down[i]) begin
            state_d[i]  = HELD;
            db_cnt_d[i] = '0;
          end else if (db_cnt_q[i] == DB_LAST) begin
            state_d[i]  = IDLE;
            db_cnt_d[i] = '0;
            level_d[i]  = 1'b0;
          end else begin
            db_cnt_d[i] = db_cnt_q[i] + DW'(1);
          end
        end
        default: begin
          state_d[i]  = IDLE;
          db_cnt_d[i] = '0;
        end
      endcase
    end
  end

  // FSM state, debounce counters and registered key outputs.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        state_q[i]  <= IDLE;
        db_cnt_q[i] <= '0;
`ifdef PANEL_AUTO_REPEAT_EN
        rpt_cnt_q[i] <= '0;
`endif
      end
`ifdef PANEL_AUTO_REPEAT_EN
      rpt_armed_q <= 2'b00;
`endif
      key_level   <= 2'b00;
      key_pressed <= 2'b00;
      run         <= 1'b1;
      dir_up      <= 1'b1;
    end else begin
      for (int i = 0; i < 2; i++) begin
        state_q[i]  <= state_d[i];
        db_cnt_q[i] <= db_cnt_d[i];
`ifdef PANEL_AUTO_REPEAT_EN
        rpt_cnt_q[i] <= rpt_cnt_d[i];
`endif
      end
`ifdef PANEL_AUTO_REPEAT_EN
      rpt_armed_q <= rpt_armed_d;
`endif
      key_level   <= level_d;
      key_pressed <= press_d;
      run         <= run ^ accept_d[0];
      dir_up      <= dir_up ^ accept_d[1];
    end
  end

  // Period end count for the latched speed: (SW+1)*TICK_BASE-1.
  assign tick_last = TW'((32'(sw_lat_q) + 32'd1) * TICK_BASE - 32'd1);

  // Step tick generator; SW is captured only when a new period starts.
  always_ff @(posedge CLOCK_50) begin
    if (reset || !run) begin
      tick_cnt_q <= '0;
      step_tick  <= 1'b0;
      sw_lat_q   <= SW;
    end else if (tick_cnt_q == tick_last) begin
      tick_cnt_q <= '0;
      step_tick  <= 1'b1;
      sw_lat_q   <= SW;
    end else begin
      tick_cnt_q <= tick_cnt_q + TW'(1);
      step_tick  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_panel_input_ctrl.sv
// tb_panel_input_ctrl: directed scenarios plus randomized key/switch traffic
// checked against a run-length debounce and elapsed-time tick model.
module tb_panel_input_ctrl;

  localparam int unsigned D  = 4;
  localparam int unsigned TB = 3;
  localparam int unsigned RD = 10;
  localparam int unsigned RP = 5;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] KEY;
  logic [3:0] SW;
  logic [1:0] key_level, key_pressed;
  logic       run, dir_up, step_tick;

  int n_cmp = 0;
  int n_bad = 0;

  panel_input_ctrl #(
    .DEBOUNCE_COUNT(D),
    .TICK_BASE     (TB),
    .REPEAT_DELAY  (RD),
    .REPEAT_PERIOD (RP)
  ) dut (
    .CLOCK_50   (clk),
    .reset      (reset),
    .KEY        (KEY),
    .SW         (SW),
    .key_level  (key_level),
    .key_pressed(key_pressed),
    .run        (run),
    .dir_up     (dir_up),
    .step_tick  (step_tick)
  );

  always #5 clk = ~clk;

  // Reference model: a key level flips after D+1 consecutive opposite
  // samples of the key delayed by two clocks; ticks every (SW+1)*TB cycles.
  logic [1:0] h1, h2;
  int         m_runlen [2];
  bit   [1:0] m_level, m_pulse;
  bit         m_run, m_dir, m_tick;
  int         m_elapsed, m_period;
`ifdef PANEL_AUTO_REPEAT_EN
  int         m_held [2];
  bit   [1:0] m_armed;
`endif

  always @(posedge clk) begin
    bit pr;
    if (reset || !m_run) begin
      m_elapsed = 0;
      m_period  = (int'(SW) + 1) * TB;
      m_tick    = 1'b0;
    end else begin
      m_elapsed++;
      if (m_elapsed == m_period) begin
        m_tick    = 1'b1;
        m_elapsed = 0;
        m_period  = (int'(SW) + 1) * TB;
      end else begin
        m_tick = 1'b0;
      end
    end
    if (reset) begin
      h1 = 2'b11; h2 = 2'b11;
      m_level = 2'b00; m_pulse = 2'b00; m_run = 1'b1; m_dir = 1'b1;
      m_runlen[0] = 0; m_runlen[1] = 0;
`ifdef PANEL_AUTO_REPEAT_EN
      m_held[0] = 0; m_held[1] = 0; m_armed = 2'b00;
`endif
    end else begin
      for (int i = 0; i < 2; i++) begin
        pr = ~h2[i];
        m_pulse[i] = 1'b0;
        if (pr != m_level[i]) begin
          m_runlen[i]++;
          if (m_runlen[i] == D + 1) begin
            m_level[i]  = pr;
            m_runlen[i] = 0;
            if (pr) begin
              m_pulse[i] = 1'b1;
              if (i == 0) m_run = ~m_run;
              else        m_dir = ~m_dir;
`ifdef PANEL_AUTO_REPEAT_EN
              m_held[i]  = 0;
              m_armed[i] = 1'b0;
`endif
            end
          end
        end else begin
`ifdef PANEL_AUTO_REPEAT_EN
          if (m_level[i] && m_runlen[i] == 0) begin
            m_held[i]++;
            if (m_held[i] == (m_armed[i] ? RP : RD)) begin
              m_pulse[i] = 1'b1;
              m_held[i]  = 0;
              m_armed[i] = 1'b1;
            end
          end
`endif
          m_runlen[i] = 0;
        end
      end
      h2 = h1;
      h1 = KEY;
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    KEY = 2'b11; SW = 4'd2;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (key_level !== 2'b00) begin n_bad++; $display("FAIL reset_key_level: got %b expected 00", key_level); end
    n_cmp++; if (key_pressed !== 2'b00) begin n_bad++; $display("FAIL reset_key_pressed: got %b expected 00", key_pressed); end
    n_cmp++; if (run !== 1'b1) begin n_bad++; $display("FAIL reset_run: got %b expected 1", run); end
    n_cmp++; if (dir_up !== 1'b1) begin n_bad++; $display("FAIL reset_dir_up: got %b expected 1", dir_up); end
    n_cmp++; if (step_tick !== 1'b0) begin n_bad++; $display("FAIL reset_step_tick: got %b expected 0", step_tick); end
    reset = 1'b0;
  endtask

  // SW=2 gives a 9-cycle period; switching to 0 mid-period shortens only later periods.
  task automatic test_tick_sw();
    bit exp;
    for (int i = 1; i <= 45; i++) begin
      @(negedge clk);
      exp = (i <= 27) ? (i % 9 == 0) : ((i - 27) % 3 == 0);
      n_cmp++;
      if (step_tick !== exp) begin
        n_bad++; $display("FAIL tick_period cycle %0d: got %b expected %b", i, step_tick, exp);
      end
      if (i == 20) SW = 4'd0;
    end
  endtask

  task automatic test_press_latency();
    KEY = 2'b11; SW = 4'd0;
    do_reset();
    repeat (2) @(negedge clk);
    KEY = 2'b10;
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      n_cmp++;
      if (key_pressed !== ((k == 6) ? 2'b01 : 2'b00)) begin
        n_bad++; $display("FAIL press_pulse k=%0d: got %b expected %b", k, key_pressed, (k == 6) ? 2'b01 : 2'b00);
      end
      n_cmp++;
      if (run !== (k < 6)) begin n_bad++; $display("FAIL press_run k=%0d: got %b expected %b", k, run, k < 6); end
      n_cmp++;
      if (key_level[0] !== (k >= 6)) begin n_bad++; $display("FAIL press_level k=%0d: got %b expected %b", k, key_level[0], k >= 6); end
    end
    KEY = 2'b11;
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      n_cmp++;
      if (key_level[0] !== (k < 6)) begin n_bad++; $display("FAIL release_level k=%0d: got %b expected %b", k, key_level[0], k < 6); end
      n_cmp++;
      if (key_pressed !== 2'b00) begin n_bad++; $display("FAIL release_pulse k=%0d: got %b expected 00", k, key_pressed); end
      n_cmp++;
      if (run !== 1'b0) begin n_bad++; $display("FAIL release_run k=%0d: got %b expected 0", k, run); end
    end
  endtask

  task automatic test_bounce();
    KEY = 2'b11;
    do_reset();
    for (int c = 0; c < 20; c++) begin
      KEY[1] = (c < 3) ? 1'b0 : (c == 3) ? 1'b1 : (c < 6) ? 1'b0 : 1'b1;
      @(negedge clk);
      n_cmp++;
      if (key_pressed[1] !== 1'b0) begin n_bad++; $display("FAIL bounce_pulse c=%0d: got %b expected 0", c, key_pressed[1]); end
      n_cmp++;
      if (dir_up !== 1'b1) begin n_bad++; $display("FAIL bounce_dir_up c=%0d: got %b expected 1", c, dir_up); end
      n_cmp++;
      if (key_level[1] !== 1'b0) begin n_bad++; $display("FAIL bounce_level c=%0d: got %b expected 0", c, key_level[1]); end
    end
  endtask

  // Both keys together, stopped ticks, then restart with a full first period.
  task automatic test_simultaneous();
    bit exp;
    KEY = 2'b11; SW = 4'd1;
    do_reset();
    KEY = 2'b00;
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      n_cmp++;
      if (key_pressed !== ((k == 6) ? 2'b11 : 2'b00)) begin
        n_bad++; $display("FAIL both_pulse k=%0d: got %b expected %b", k, key_pressed, (k == 6) ? 2'b11 : 2'b00);
      end
    end
    n_cmp++; if (run !== 1'b0) begin n_bad++; $display("FAIL both_run: got %b expected 0", run); end
    n_cmp++; if (dir_up !== 1'b0) begin n_bad++; $display("FAIL both_dir_up: got %b expected 0", dir_up); end
    n_cmp++; if (key_level !== 2'b11) begin n_bad++; $display("FAIL both_level: got %b expected 11", key_level); end
    KEY = 2'b11;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      n_cmp++;
      if (step_tick !== 1'b0) begin n_bad++; $display("FAIL stopped_tick k=%0d: got %b expected 0", k, step_tick); end
    end
    KEY = 2'b10;
    for (int k = 0; k <= 20; k++) begin
      @(negedge clk);
      exp = (k > 6) && ((k - 6) % 6 == 0);
      n_cmp++;
      if (run !== (k >= 6)) begin n_bad++; $display("FAIL restart_run k=%0d: got %b expected %b", k, run, k >= 6); end
      n_cmp++;
      if (step_tick !== exp) begin n_bad++; $display("FAIL restart_tick k=%0d: got %b expected %b", k, step_tick, exp); end
    end
    KEY = 2'b11;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int np;
    KEY = 2'b11; SW = 4'd0;
    do_reset();
    KEY = 2'b10;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (key_level !== 2'b00) begin n_bad++; $display("FAIL midrst_level: got %b expected 00", key_level); end
    n_cmp++; if (key_pressed !== 2'b00) begin n_bad++; $display("FAIL midrst_pulse: got %b expected 00", key_pressed); end
    n_cmp++; if (run !== 1'b1) begin n_bad++; $display("FAIL midrst_run: got %b expected 1", run); end
    n_cmp++; if (dir_up !== 1'b1) begin n_bad++; $display("FAIL midrst_dir_up: got %b expected 1", dir_up); end
    n_cmp++; if (step_tick !== 1'b0) begin n_bad++; $display("FAIL midrst_tick: got %b expected 0", step_tick); end
    @(negedge clk);
    reset = 1'b0;
    np = 0;
    for (int k = 0; k <= D + 6; k++) begin
      @(negedge clk);
      if (key_pressed[0]) np++;
      n_cmp++;
      if (key_pressed[0] !== (k == D + 2)) begin
        n_bad++; $display("FAIL postrst_pulse k=%0d: got %b expected %b", k, key_pressed[0], k == D + 2);
      end
    end
    n_cmp++; if (np != 1) begin n_bad++; $display("FAIL postrst_count: got %0d expected 1", np); end
    n_cmp++; if (run !== 1'b0) begin n_bad++; $display("FAIL postrst_run: got %b expected 0", run); end
    KEY = 2'b11;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_auto_repeat();
    bit exp;
    KEY = 2'b11;
    do_reset();
    KEY = 2'b10;
    for (int k = 0; k <= 36; k++) begin
      @(negedge clk);
`ifdef PANEL_AUTO_REPEAT_EN
      exp = (k == 6) || (k >= 6 + RD && (k - 6 - RD) % RP == 0);
`else
      exp = (k == 6);
`endif
      n_cmp++;
      if (key_pressed[0] !== exp) begin n_bad++; $display("FAIL repeat_pulse k=%0d: got %b expected %b", k, key_pressed[0], exp); end
    end
    n_cmp++; if (run !== 1'b0) begin n_bad++; $display("FAIL repeat_run: got %b expected 0", run); end
    KEY = 2'b11;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_random();
    int left0, left1;
    KEY = 2'b11; SW = 4'($urandom_range(0, 15));
    do_reset();
    left0 = 0; left1 = 0;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      n_cmp++; if (key_pressed !== m_pulse) begin n_bad++; $display("FAIL rnd_pulse c=%0d: got %b expected %b", c, key_pressed, m_pulse); end
      n_cmp++; if (key_level !== m_level) begin n_bad++; $display("FAIL rnd_level c=%0d: got %b expected %b", c, key_level, m_level); end
      n_cmp++; if (run !== m_run) begin n_bad++; $display("FAIL rnd_run c=%0d: got %b expected %b", c, run, m_run); end
      n_cmp++; if (dir_up !== m_dir) begin n_bad++; $display("FAIL rnd_dir_up c=%0d: got %b expected %b", c, dir_up, m_dir); end
      n_cmp++; if (step_tick !== m_tick) begin n_bad++; $display("FAIL rnd_tick c=%0d: got %b expected %b", c, step_tick, m_tick); end
      if (left0 <= 0) begin KEY[0] = ~KEY[0]; left0 = int'($urandom_range(1, 3 * D + 4)); end
      if (left1 <= 0) begin KEY[1] = ~KEY[1]; left1 = int'($urandom_range(1, 3 * D + 4)); end
      left0--; left1--;
      if ($urandom_range(0, 39) == 0) SW = 4'($urandom_range(0, 15));
      reset = ($urandom_range(0, 299) == 0);
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; KEY = 2'b11; SW = 4'd2;
    @(negedge clk);
    test_reset();
    test_tick_sw();
    test_press_latency();
    test_bounce();
    test_simultaneous();
    test_reset_mid();
    test_auto_repeat();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/panel_input_ctrl.md
PANEL_INPUT_CTRL -- requirements
Module: panel_input_ctrl

Interface
REQ-001 Parameter DEBOUNCE_COUNT, default 500000, is the number of consecutive stable synchronized samples (10 ms at 50 MHz) required to accept a key change.
REQ-002 Parameter TICK_BASE, default 2500000, is the base step period in clock cycles.
REQ-003 Parameter REPEAT_DELAY, default 25000000, is the cycles a key is held before auto-repeat starts.
REQ-004 Parameter REPEAT_PERIOD, default 5000000, is the cycles between auto-repeat pulses.
REQ-005 CLOCK_50  in  1  the only clock; all logic is on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 KEY  in  2  raw asynchronous pushbuttons, active-low (0 = pressed).
REQ-008 SW  in  4  speed select, sampled synchronously.
REQ-009 key_level  out  2  debounced key state, active-high (1 = pressed).
REQ-010 key_pressed  out  2  one-cycle pulse per accepted press (and per repeat when enabled).
REQ-011 run  out  1  scan enable, toggled by each accepted KEY[0] press.
REQ-012 dir_up  out  1  scan direction, toggled by each accepted KEY[1] press.
REQ-013 step_tick  out  1  one-cycle pulse marking one scanner step.

Function
REQ-014 Each KEY bit passes through a 2-flop synchronizer, with both flops resetting to 1 (released), before any other use.
REQ-015 Each key has an independent FSM with states IDLE, PRESS_WAIT, HELD and RELEASE_WAIT, and its own debounce counter.
REQ-016 IDLE -> PRESS_WAIT when the synchronized key reads 0; the counter clears.
REQ-017 PRESS_WAIT: the counter increments while the key reads 0, any 1 returns to IDLE (bounce rejected, no event), and reaching DEBOUNCE_COUNT moves to HELD, sets key_level=1 and pulses key_pressed for one cycle.
REQ-018 HELD -> RELEASE_WAIT when the key reads 1; RELEASE_WAIT needs DEBOUNCE_COUNT consecutive 1 samples to reach IDLE and clear key_level, and any 0 sample returns to HELD with no new pulse.
REQ-019 Press latency is fixed: with KEY low from edge N onward, key_pressed is high in the cycle after edge N+2+DEBOUNCE_COUNT.
REQ-020 run and dir_up toggle on the same edge that asserts the corresponding key_pressed initial pulse; repeat pulses never toggle them.
REQ-021 Simultaneous presses on both keys are processed independently in the same cycle.
REQ-022 The tick counter runs only while run=1 and pulses step_tick when it reaches (SW+1)*TICK_BASE-1, then reloads to 0; the period range is 1..16 times TICK_BASE, computed without overflow.
REQ-023 SW is latched only at counter reload, so a mid-period SW change takes effect from the next period.
REQ-024 When run=0 the tick counter holds at 0 and step_tick=0; when run returns to 1 the first tick follows a full period.

Reset
REQ-025 On reset: both FSMs go to IDLE, all counters are 0, key_level=0, key_pressed=0, run=1, dir_up=1 and step_tick=0.
REQ-026 Reset asserted mid-debounce or mid-hold discards the event; a key still held after reset is debounced afresh from IDLE and yields one press.

Configuration
REQ-027 Macro PANEL_AUTO_REPEAT_EN: when defined, a key in HELD for REPEAT_DELAY cycles emits a key_pressed pulse, then another every REPEAT_PERIOD cycles until release; when undefined, there is no repeat logic and exactly one pulse per press.

Verification
REQ-028 DEBOUNCE_COUNT=4: KEY[0] held low from edge 10 -> key_pressed[0] high in the cycle after edge 16 only; run goes 1->0 at edge 16; key_level[0]=1.
REQ-029 KEY[1] bounces low 3 cycles, high 1, low 2, then high -> no key_pressed[1] pulse; dir_up stays 1.
REQ-030 TICK_BASE=3, SW=2, run=1 -> step_tick every 9 cycles; SW changed to 0 mid-period -> the current period completes at 9, then every 3.
REQ-031 Both KEYs pressed on the same edge -> both pulses in the same cycle; run=0 and dir_up=0; step_tick stops and the counter holds at 0.
REQ-032 Reset asserted during PRESS_WAIT with KEY held -> all outputs return to their reset values; a single pulse occurs DEBOUNCE_COUNT+2 cycles after reset deasserts.
REQ-033 With PANEL_AUTO_REPEAT_EN, REPEAT_DELAY=10, REPEAT_PERIOD=5 and KEY[0] held 30 cycles past acceptance -> pulses at +0, +10, +15, +20, +25 and +30; run toggles once.
